// File: rtl/trigger_stream_monitor.sv
// Trigger stream monitor: detects rising edges on packed trigger bits, applies
// per-beam holdoff, counts events, queues timestamped events, Wishbone CSRs.
module trigger_stream_monitor #(
    parameter int unsigned NBEAMS  = 2,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [127:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic         wb_cyc_i,
    input  logic         wb_stb_i,
    input  logic         wb_we_i,
    input  logic [21:0]  wb_adr_i,
    input  logic [31:0]  wb_dat_i,
    input  logic [3:0]   wb_sel_i,
    output logic [31:0]  wb_dat_o,
    output logic         wb_ack_o,
    output logic         irq_o
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned EW    = 32 + NBEAMS;

    // Reset synchronizer: asserts asynchronously, releases on aclk
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // State
    logic [31:0]        ts;
    logic               enable;
    logic [NBEAMS-1:0]  mask;
    logic [15:0]        holdoff;
    logic [NBEAMS-1:0]  prev;
    logic [15:0]        hcnt   [NBEAMS];
    logic [31:0]        scaler [NBEAMS];
    logic [EW-1:0]      mem    [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [15:0]        ovfcnt;
    logic               ovf;
    logic [NBEAMS-1:0]  evt_mask;
    logic               clr_pend, clr_now;

    // Unpack the 12-bit trigger fields out of the 16-bit lanes
    logic [95:0]        vec;
    logic [NBEAMS-1:0]  trig;
    always_comb begin
        vec = '0;
        for (int i = 0; i < 8; i++) vec[12*i +: 12] = s_tdata[16*i+4 +: 12];
    end
    assign trig = vec[NBEAMS-1:0];

    // Wishbone request decode: a new access is a strobe not already being acked
    logic       req, wr, rd;
    logic [5:0] idx;
    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr  = req & wb_we_i;
    assign rd  = req & ~wb_we_i;
    assign idx = wb_adr_i[7:2];

    logic [EW-1:0]     head;
    logic [31:0]       head_ts;
    logic [NBEAMS-1:0] head_mask;
    assign head      = mem[rd_ptr];
    assign head_ts   = head[EW-1:NBEAMS];
    assign head_mask = head[NBEAMS-1:0];

    // Edge detection, FIFO push/pop arbitration and occupancy
    logic              accept, empty, full, pop, push, drop;
    logic [NBEAMS-1:0] evt;
    logic [CW-1:0]     count_nxt;
    always_comb begin
        accept = s_tvalid & s_tready;
        evt    = '0;
        for (int n = 0; n < NBEAMS; n++) begin
            evt[n] = accept & trig[n] & ~prev[n] & enable & mask[n]
                   & (hcnt[n] == 16'd0) & ~clr_now;
        end
        empty     = (count == CW'(0));
        full      = (count == CW'(DEPTH));
        pop       = rd & (idx == 6'd4) & ~empty;
        push      = (|evt) & (~full | pop);
        drop      = (|evt) & full & ~pop;
        count_nxt = clr_now ? CW'(0) : CW'(count + CW'(push) - CW'(pop));
    end

    // Register read mux
    logic [31:0] rdata;
    always_comb begin
        rdata = 32'd0;
        case (idx)
            6'd0: rdata = {31'd0, enable};
            6'd1: rdata = 32'(mask);
            6'd2: rdata = {16'd0, holdoff};
            6'd3: rdata = {ovf, 13'd0, full, empty, 16'(count)};
            6'd4: rdata = empty ? 32'd0 : head_ts;
            6'd5: rdata = 32'(evt_mask);
            6'd6: rdata = {16'd0, ovfcnt};
            default: begin
                for (int n = 0; n < NBEAMS; n++) begin
                    if (idx == 6'(8 + n)) rdata = scaler[n];
                end
            end
        endcase
    end

    // Event storage (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= {ts, evt};
    end

    // Control/status registers, counters and bus handshake
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            s_tready <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
            irq_o    <= 1'b0;
            ts       <= 32'd0;
            enable   <= 1'b0;
            mask     <= '1;
            holdoff  <= 16'd0;
            prev     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovfcnt   <= 16'd0;
            ovf      <= 1'b0;
            evt_mask <= '0;
            clr_pend <= 1'b0;
            clr_now  <= 1'b0;
            for (int n = 0; n < NBEAMS; n++) begin
                hcnt[n]   <= 16'd0;
                scaler[n] <= 32'd0;
            end
        end else begin
            s_tready <= 1'b1;
            ts       <= ts + 32'd1;
            wb_ack_o <= req;
            wb_dat_o <= req ? rdata : 32'd0;
            irq_o    <= (count_nxt != CW'(0));
            count    <= count_nxt;
            clr_pend <= wr & (idx == 6'd0) & wb_dat_i[1];
            clr_now  <= clr_pend;

            if (wr) begin
                case (idx)
                    6'd0:    enable  <= wb_dat_i[0];
                    6'd1:    mask    <= wb_dat_i[NBEAMS-1:0];
                    6'd2:    holdoff <= wb_dat_i[15:0];
                    default: ;
                endcase
            end
            if (pop) evt_mask <= head_mask;

            if (clr_now) begin
                prev   <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovfcnt <= 16'd0;
                ovf    <= 1'b0;
                for (int n = 0; n < NBEAMS; n++) begin
                    hcnt[n]   <= 16'd0;
                    scaler[n] <= 32'd0;
                end
            end else begin
                if (accept) prev <= trig;
                if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
                if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
                if (drop) begin
                    ovf <= 1'b1;
                    if (ovfcnt != 16'hFFFF) ovfcnt <= ovfcnt + 16'd1;
                end
                for (int n = 0; n < NBEAMS; n++) begin
                    if (evt[n])                hcnt[n] <= holdoff;
                    else if (hcnt[n] != 16'd0) hcnt[n] <= hcnt[n] - 16'd1;
                    if (evt[n] && scaler[n] != 32'hFFFF_FFFF) scaler[n] <= scaler[n] + 32'd1;
                end
            end
        end
    end

    // Inputs that carry no meaning here (ignored lanes, byte selects, high address bits)
    logic unused_inputs;
    assign unused_inputs = ^{s_tdata, vec, wb_adr_i, wb_dat_i, wb_sel_i};

endmodule

// File: tb/tb_trigger_stream_monitor.sv
// Directed bench for trigger_stream_monitor with a register-read scoreboard.
module tb_trigger_stream_monitor;
    localparam int unsigned NB = 2;

    localparam logic [21:0] A_CTRL  = 22'h00;
    localparam logic [21:0] A_MASK  = 22'h04;
    localparam logic [21:0] A_HOLD  = 22'h08;
    localparam logic [21:0] A_STAT  = 22'h0C;
    localparam logic [21:0] A_EVTS  = 22'h10;
    localparam logic [21:0] A_EVTM  = 22'h14;
    localparam logic [21:0] A_OVFC  = 22'h18;
    localparam logic [21:0] A_SC0   = 22'h20;
    localparam logic [21:0] A_SC1   = 22'h24;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [21:0]  wb_adr = '0;
    logic [31:0]  wb_dat = '0;
    logic [3:0]   wb_sel = '0;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_o;
    logic         irq_o;

    trigger_stream_monitor #(.NBEAMS(NB), .FIFO_AW(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .irq_o(irq_o)
    );

    always #5 aclk = ~aclk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    // One valid beat; lanes outside the trigger bits carry random noise
    task automatic beat(input logic [NB-1:0] t);
        s_tdata = {$urandom, $urandom, $urandom, $urandom};
        s_tdata[4 +: NB] = t;
        s_tvalid = 1'b1;
        tick();
    endtask

    task automatic wb_xfer(input logic we, input logic [21:0] adr, input logic [31:0] wd,
                           output logic [31:0] rdat, output logic ok);
        int n;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr;  wb_dat = wd;   wb_sel = 4'hF;
        n = 0;
        do begin
            tick();
            n++;
        end while (wb_ack_o !== 1'b1 && n < 8);
        ok   = (wb_ack_o === 1'b1);
        rdat = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL wb_ack_timeout observed=0 expected=1 adr=0x%0h", adr);
        end
    endtask

    task automatic wb_write(input logic [21:0] adr, input logic [31:0] d);
        logic [31:0] r;
        logic        ok;
        wb_xfer(1'b1, adr, d, r, ok);
    endtask

    task automatic wb_read_raw(input logic [21:0] adr, output logic [31:0] d);
        logic ok;
        wb_xfer(1'b0, adr, 32'd0, d, ok);
    endtask

    // Scoreboarded read: expectation queued at issue, checked when the ack returns
    task automatic wb_read(input logic [21:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] d, e;
        logic        ok;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        wb_xfer(1'b0, adr, 32'd0, d, ok);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (ok) chk(t, d, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base, d;

        // Reset values
        repeat (3) tick();
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_ack",    32'(wb_ack_o), 32'd0);
        chk("rst_dat",    wb_dat_o,      32'd0);
        chk("rst_irq",    32'(irq_o),    32'd0);
        aresetn = 1'b1;
        repeat (5) tick();
        chk("tready_up", 32'(s_tready), 32'd1);
        wb_read(A_MASK, 32'h3, "mask_rst");
        wb_read(A_STAT, 32'h0001_0000, "status_rst");

        // Beam0 0,1,1,0,1 on consecutive beats -> two edges
        wb_write(A_CTRL, 32'h1);
        beat(2'b00); beat(2'b01); beat(2'b01); beat(2'b00); beat(2'b01);
        idle(2);
        wb_read(A_SC0,  32'd2, "edge_sc0");
        wb_read(A_SC1,  32'd0, "edge_sc1");
        wb_read(A_STAT, 32'h0000_0002, "edge_status");
        chk("edge_irq", 32'(irq_o), 32'd1);
        wb_read(A_EVTM, 32'd0, "evtm_before_pop");
        wb_read_raw(A_EVTS, d);
        wb_read(A_EVTM, 32'd1, "evtm_after_pop");
        wb_read(A_STAT, 32'h0000_0001, "status_after_pop");
        wb_write(A_CTRL, 32'h3);
        idle(2);
        wb_read(A_STAT, 32'h0001_0000, "clear_status");
        wb_read(A_SC0,  32'd0, "clear_sc0");
        wb_read(A_CTRL, 32'h1, "ctrl_readback");
        chk("clear_irq", 32'(irq_o), 32'd0);

        // Both beams on one beat, then beam1 masked off
        beat(2'b11); beat(2'b00);
        idle(2);
        wb_read(A_STAT, 32'h0000_0001, "both_status");
        wb_read_raw(A_EVTS, d);
        wb_read(A_EVTM, 32'd3, "both_evtm");
        wb_read(A_SC1,  32'd1, "both_sc1");
        wb_write(A_MASK, 32'h1);
        wb_read(A_MASK, 32'h1, "mask_rw");
        beat(2'b11); beat(2'b00);
        idle(2);
        wb_read_raw(A_EVTS, d);
        wb_read(A_EVTM, 32'd1, "masked_evtm");
        wb_read(A_SC1,  32'd1, "masked_sc1");
        wb_read(A_SC0,  32'd2, "masked_sc0");
        wb_write(A_MASK, 32'h3);
        wb_write(A_CTRL, 32'h3);
        idle(2);

        // Holdoff 10: beam1 rises every 4 cycles, accepted at 0,12,24,36
        wb_write(A_HOLD, 32'd10);
        wb_read(A_HOLD, 32'd10, "hold_rw");
        for (int k = 0; k < 20; k++) begin
            beat((k % 2 == 0) ? 2'b10 : 2'b00);
            idle(1);
        end
        idle(2);
        wb_read(A_SC1,  32'd4, "hold_sc1");
        wb_read(A_SC0,  32'd0, "hold_sc0");
        wb_read(A_STAT, 32'h0000_0004, "hold_status");
        wb_write(A_CTRL, 32'h3);
        wb_write(A_HOLD, 32'd0);
        idle(2);

        // 20 events spaced two cycles apart overflow a 16-entry FIFO
        for (int k = 0; k < 40; k++) beat((k % 2 == 0) ? 2'b01 : 2'b00);
        idle(2);
        wb_read(A_STAT, 32'h8002_0010, "ovf_status");
        wb_read(A_OVFC, 32'd4, "ovf_count");
        chk("ovf_irq", 32'(irq_o), 32'd1);
        wb_read_raw(A_EVTS, base);
        for (int k = 1; k < 16; k++) begin
            wb_read(A_EVTS, base + 32'(2 * k), $sformatf("evt_ts%0d", k));
        end
        wb_read(A_STAT, 32'h8001_0000, "drained_status");
        wb_read(A_EVTS, 32'd0, "empty_evts");
        wb_read(A_EVTM, 32'd1, "empty_evtm");
        chk("drained_irq", 32'(irq_o), 32'd0);
        wb_write(A_CTRL, 32'h3);
        idle(2);
        wb_read(A_OVFC, 32'd0, "clear_ovfc");

        // Reset mid-burst with FIFO non-empty and beam0 held high
        for (int k = 0; k < 3; k++) begin
            beat(2'b01); beat(2'b00);
        end
        beat(2'b01);
        chk("pre_rst_irq", 32'(irq_o), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tready", 32'(s_tready), 32'd0);
        chk("mid_rst_irq",    32'(irq_o),    32'd0);
        chk("mid_rst_ack",    32'(wb_ack_o), 32'd0);
        chk("mid_rst_dat",    wb_dat_o,      32'd0);
        s_tvalid = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        repeat (5) tick();
        wb_read(A_STAT, 32'h0001_0000, "post_rst_status");
        wb_read(A_SC0,  32'd0, "post_rst_sc0");
        wb_read(A_CTRL, 32'd0, "post_rst_ctrl");
        wb_write(A_CTRL, 32'h1);
        beat(2'b01);
        idle(2);
        wb_read(A_SC0,  32'd1, "post_rst_level_edge");
        wb_read(A_STAT, 32'h0000_0001, "post_rst_fifo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trigger_stream_monitor.md
TRIGGER_STREAM_MONITOR -- requirements
Module: trigger_stream_monitor

Interface
REQ-001 SHALL have parameter NBEAMS, default 2, number of trigger bits monitored (legal 1..32).
REQ-002 SHALL have parameter FIFO_AW, default 4, log2 of event FIFO depth.
REQ-003 SHALL have port aclk, input, 1, the single clock for all logic including the Wishbone side.
REQ-004 SHALL have port aresetn, input, 1, reset that is asynchronous and active-low; this choice is already decided and fixed.
REQ-005 SHALL have AXI4-Stream target ports s_tdata (input, 128, packed trigger word), s_tvalid (input, 1, beat valid) and s_tready (output, 1, beat accept).
REQ-006 SHALL have Wishbone target ports wb_cyc_i (1), wb_stb_i (1), wb_we_i (1), wb_adr_i (22), wb_dat_i (32) and wb_sel_i (4) as inputs, and wb_dat_o (32) and wb_ack_o (1) as outputs.
REQ-007 SHALL have port irq_o, output, 1, high while the event FIFO is non-empty.

Function
REQ-008 Unpack: SHALL form a 96-bit vector whose field i (i=0..7) is s_tdata[16i+4 +: 12]; trigger vector trig = vector[NBEAMS-1:0]; s_tdata[16i +: 4] ignored.
REQ-009 s_tready SHALL be 1 whenever aresetn is high; the block never backpressures. A beat is accepted when s_tvalid=1.
REQ-010 SHALL run a free 32-bit timestamp counter, +1 every cycle, wrapping 0xFFFFFFFF->0.
REQ-011 SHALL hold a previous-trigger register prev[NBEAMS-1:0], updated only on accepted beats; no beat -> no edges.
REQ-012 Beam n event on accepted beat when: trig[n]=1, prev[n]=0, CTRL.enable=1, MASK[n]=1 and holdoff_cnt[n]=0.
REQ-013 On a beam-n event holdoff_cnt[n] SHALL load HOLDOFF[15:0] then decrement per cycle to 0; HOLDOFF=0 means no suppression.
REQ-014 Per-beam 32-bit scaler SHALL increment on each beam-n event and saturate at 0xFFFFFFFF.
REQ-015 If any beam has an event in a cycle, SHALL push one FIFO entry {timestamp of that cycle, event mask[NBEAMS-1:0]}; FIFO depth 2^FIFO_AW, data visible on read one cycle after push.
REQ-016 FIFO full with no same-cycle pop: entry dropped, 16-bit OVFCNT +1 (saturating at 0xFFFF), STATUS.ovf sticky set. Full plus same-cycle pop: push accepted.
REQ-017 Wishbone: wb_ack_o SHALL pulse one cycle, one cycle after a cycle where wb_cyc_i&wb_stb_i=1 and wb_ack_o=0; no wait states, no error. Write data/sel ignored on read-only registers; wb_sel_i ignored elsewhere.
REQ-018 Register map (wb_adr_i[7:2]): 0x00 CTRL (bit0 enable RW; bit1 clear, write-1 self-clearing, reads 0), 0x04 MASK RW, 0x08 HOLDOFF RW [15:0], 0x0C STATUS RO {ovf[31], full[17], empty[16], count[15:0]}, 0x10 EVT_TS RO-pop, 0x14 EVT_MASK RO, 0x18 OVFCNT RO, 0x20+4n SCALER[n] RO; unmapped addresses read 0.
REQ-019 Reading EVT_TS when non-empty SHALL return head timestamp, pop the FIFO, and latch the head mask into EVT_MASK; when empty it returns 0, no pop, EVT_MASK unchanged.
REQ-020 A CTRL clear write SHALL, on the cycle after the write is acknowledged, zero scalers, FIFO, OVFCNT, STATUS.ovf, prev and holdoff counters; events in that cycle are discarded; timestamp is not cleared.
REQ-021 Events in the same cycle as a clear write being acknowledged SHALL still count and be pushed; the following clear removes them.

Reset
REQ-022 aresetn low SHALL asynchronously force: s_tready=0, wb_ack_o=0, wb_dat_o=0, irq_o=0, timestamp=0, CTRL=0, MASK={NBEAMS{1}}, HOLDOFF=0, scalers=0, FIFO empty, OVFCNT=0, ovf=0, prev=0, holdoff counters=0.
REQ-023 Deassertion SHALL be synchronized to aclk; the first accepted beat after reset sees prev=0.

Verification
REQ-024 Enable=1, beam0 bit (s_tdata[4]) 0,1,1,0,1 on consecutive valid beats, HOLDOFF=0 -> SCALER[0]=2, FIFO count 2.
REQ-025 HOLDOFF=10, beam1 toggles 1/0 every beat for 20 beats -> only pulses at least 10 cycles after the previous event count; SCALER[1]=4.
REQ-026 FIFO_AW=4, 20 separate events with no reads -> count 16, full=1, OVFCNT=4, ovf=1; 16 EVT_TS reads return timestamps in increasing order, then empty=1 and the next read returns 0.
REQ-027 Both beams rise on the same beat -> one entry with EVT_MASK=0b11; MASK=0b01 -> EVT_MASK=0b01 and SCALER[1] unchanged.
REQ-028 aresetn asserted mid-burst with FIFO non-empty -> all outputs at reset values immediately; after release FIFO is empty, scalers are 0, and a level-high beam counts as a new edge.
